memory_stage: RTL

- Memory stage of the WISC pipeline. It consumes the execute stage's result word (ALUO) and store data, and runs a multi-cycle request/done handshake to a stalling data memory.
- It produces a registered writeback word, which is the load data or the ALU result.
- It back-pressures execute through in_ready while an access is outstanding.
- It flags illegal or timed-out accesses on a sticky err, matching the err convention of the other stages.

---
 rtl/memory_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage: WISC pipeline memory stage. Runs a request/done access to a stalling data memory and
// produces a registered writeback word. Optional macro ALIGN_CHK_EN rejects odd-address loads/stores.
module memory_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ALUO,
    input  logic [15:0] WrData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic [2:0]  WrReg,
    input  logic        Halt,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        out_valid,
    output logic [15:0] out_WbData,
    output logic        out_RegWrite,
    output logic [2:0]  out_WrReg,
    output logic        out_halt,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HALTED, ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             hold_wr, hold_regwrite;
    logic [2:0]       hold_wrreg;
    logic             is_mem, reject, accept, done_ok, timed_out;

    // Handshakes: an instruction transfers on a rising edge with in_valid && in_ready; a memory
    // access is one mem_req strobe, finished by mem_done in the strobe cycle or any later cycle.
    assign is_mem = MemRead | MemWrite;
`ifdef ALIGN_CHK_EN
    assign reject = (MemRead & MemWrite) | (is_mem & ALUO[0]);
`else
    assign reject = MemRead & MemWrite;
`endif
    assign accept    = in_valid & in_ready;
    assign done_ok   = ((state == REQ) || (state == WAIT)) && mem_done;
    assign timed_out = (state == WAIT) && !mem_done && (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    if (reject)      state_nxt = ERR;
                    else if (is_mem) state_nxt = REQ;
                    else if (Halt)   state_nxt = HALTED;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_wr    = hold_wr;
                state_nxt = mem_done ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem_done)       state_nxt = IDLE;
                else if (timed_out) state_nxt = ERR;
            end
            HALTED, ERR: state_nxt = state;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            hold_wr       <= 1'b0;
            hold_regwrite <= 1'b0;
            hold_wrreg    <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            out_valid     <= 1'b0;
            out_WbData    <= '0;
            out_RegWrite  <= 1'b0;
            out_WrReg     <= '0;
            out_halt      <= 1'b0;
            err           <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_halt  <= 1'b0;
            if (accept && reject) begin
                err <= 1'b1;
            end else if (accept && is_mem) begin
                mem_addr      <= ALUO;
                mem_wdata     <= WrData;
                hold_wr       <= MemWrite;
                hold_regwrite <= RegWrite & ~MemWrite;
                hold_wrreg    <= WrReg;
            end else if (accept) begin
                out_valid    <= 1'b1;
                out_WbData   <= ALUO;
                out_RegWrite <= RegWrite;
                out_WrReg    <= WrReg;
                out_halt     <= Halt;
            end
            if (state == REQ)  cnt <= CNT_W'(1);
            if (state == WAIT) cnt <= cnt + CNT_W'(1);
            // Stores write back their address; loads the data captured with mem_done.
            if (done_ok) begin
                out_valid    <= 1'b1;
                out_WbData   <= hold_wr ? mem_addr : mem_rdata;
                out_RegWrite <= hold_regwrite;
                out_WrReg    <= hold_wrreg;
            end
            if (timed_out) err <= 1'b1;
        end
    end
endmodule
